// File: rtl/stack_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stack_seq_pkg                                                      |
// | Shared types for the stack command sequencer: opcode, response     |
// | status and FSM state encodings.                                    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package stack_seq_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    NOP_ILLEGAL = 2'b00,
    PUSH        = 2'b01,
    POP         = 2'b10,
    TOP         = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    FULL    = 2'b01,
    EMPTY   = 2'b10,
    ILLEGAL = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    CAPTURE   = 3'd2,
    ISSUE_POP = 3'd3,
    RESP      = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stack_cmd_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stack_cmd_if / stack_port_if                                       |
// | stack_cmd_if : command + response valid/ready streams.             |
// |   master = command requester, slave = sequencer.                   |
// |   cmd_valid/cmd_op/cmd_data/rsp_ready  requester -> sequencer      |
// |   cmd_ready/rsp_valid/rsp_data/rsp_status  sequencer -> requester  |
// | stack_port_if : strobe port towards the stack.                     |
// |   master = sequencer, slave = stack.                               |
// |   stk_enable/push/pop/top/data_in  sequencer -> stack              |
// |   stk_data_out/overflow/is_empty   stack -> sequencer              |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface stack_cmd_if #(
  parameter int BITWIDTH = 8
) ();
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [stack_seq_pkg::OP_W-1:0]   cmd_op;
  logic [BITWIDTH-1:0]              cmd_data;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [BITWIDTH-1:0]              rsp_data;
  logic [1:0]                       rsp_status;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface

interface stack_port_if #(
  parameter int BITWIDTH = 8
) ();
  logic                stk_enable;
  logic                stk_push;
  logic                stk_pop;
  logic                stk_top;
  logic [BITWIDTH-1:0] stk_data_in;
  logic [BITWIDTH-1:0] stk_data_out;
  logic                stk_overflow;
  logic                stk_is_empty;

  modport master (
    output stk_enable, stk_push, stk_pop, stk_top, stk_data_in,
    input  stk_data_out, stk_overflow, stk_is_empty
  );

  modport slave (
    input  stk_enable, stk_push, stk_pop, stk_top, stk_data_in,
    output stk_data_out, stk_overflow, stk_is_empty
  );
endinterface
`default_nettype wire

// File: rtl/stack_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stack_cmd_sequencer                                                |
// | Converts accepted stack commands into single-cycle push/pop/top    |
// | strobes, refusing commands the stack flags say are illegal, and    |
// | returns one registered response per command.                       |
// | Ports: clk, rst_n (async, active low),                             |
// |   cmd : stack_cmd_if.slave   (command in / response out)           |
// |   stk : stack_port_if.master (strobes out / flags + data in)       |
// | Option: STACK_SEQ_POP_DATA_EN - POP runs TOP, CAPTURE, ISSUE_POP   |
// |   so the response carries the popped word.                         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module stack_cmd_sequencer
  import stack_seq_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int STACKSIZE = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  stack_cmd_if.slave  cmd,
  stack_port_if.master stk
);

  // Depth is only meaningful to the surrounding stack; reject nonsense.
  if (STACKSIZE < 1) begin : g_stacksize_check
    $error("STACKSIZE must be at least 1");
  end

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [BITWIDTH-1:0] stk_data_in_q, stk_data_in_d;
  logic                stk_push_q, stk_push_d;
  logic                stk_pop_q, stk_pop_d;
  logic                stk_top_q, stk_top_d;
  logic                stk_enable_q, stk_enable_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [BITWIDTH-1:0] rsp_data_q, rsp_data_d;
  status_e             rsp_status_q, rsp_status_d;
  op_e                 cmd_op;

  assign cmd_op = op_e'(cmd.cmd_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= NOP_ILLEGAL;
      stk_data_in_q <= '0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_top_q     <= 1'b0;
      stk_enable_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= OK;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      stk_data_in_q <= stk_data_in_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_top_q     <= stk_top_d;
      stk_enable_q  <= stk_enable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
    end
  end

  // Strobes are computed alongside the transition into ISSUE/ISSUE_POP so
  // their registered copies are high exactly during that state.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    stk_data_in_d = stk_data_in_q;
    stk_push_d    = 1'b0;
    stk_pop_d     = 1'b0;
    stk_top_d     = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          rsp_data_d   = '0;
          rsp_status_d = OK;
          op_d         = cmd_op;
          case (cmd_op)
            PUSH: begin
              if (stk.stk_overflow) begin
                rsp_status_d = FULL;
                state_d      = RESP;
              end else begin
                stk_data_in_d = cmd.cmd_data;
                stk_push_d    = 1'b1;
                state_d       = ISSUE;
              end
            end
            POP: begin
              if (stk.stk_is_empty) begin
                rsp_status_d = EMPTY;
                state_d      = RESP;
              end else begin
`ifdef STACK_SEQ_POP_DATA_EN
                // Read the word first so the response can carry it.
                stk_top_d = 1'b1;
`else
                stk_pop_d = 1'b1;
`endif
                state_d   = ISSUE;
              end
            end
            TOP: begin
              if (stk.stk_is_empty) begin
                rsp_status_d = EMPTY;
                state_d      = RESP;
              end else begin
                stk_top_d = 1'b1;
                state_d   = ISSUE;
              end
            end
            default: begin
              rsp_status_d = ILLEGAL;
              state_d      = RESP;
            end
          endcase
        end
      end

      ISSUE: begin
`ifdef STACK_SEQ_POP_DATA_EN
        state_d = (op_q == TOP || op_q == POP) ? CAPTURE : RESP;
`else
        state_d = (op_q == TOP) ? CAPTURE : RESP;
`endif
      end

      CAPTURE: begin
        // Stack output register was updated by the edge that ended ISSUE.
        rsp_data_d = stk.stk_data_out;
`ifdef STACK_SEQ_POP_DATA_EN
        if (op_q == POP) begin
          stk_pop_d = 1'b1;
          state_d   = ISSUE_POP;
        end else begin
          state_d   = RESP;
        end
`else
        state_d = RESP;
`endif
      end

      ISSUE_POP: begin
        state_d = RESP;
      end

      RESP: begin
        if (cmd.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    stk_enable_d = stk_push_d | stk_pop_d | stk_top_d;
    rsp_valid_d  = (state_d == RESP);
  end

  // rst_n gates ready so nothing is accepted while reset is held.
  assign cmd.cmd_ready   = (state_q == IDLE) && rst_n;
  assign cmd.rsp_valid   = rsp_valid_q;
  assign cmd.rsp_data    = rsp_data_q;
  assign cmd.rsp_status  = rsp_status_q;

  assign stk.stk_enable  = stk_enable_q;
  assign stk.stk_push    = stk_push_q;
  assign stk.stk_pop     = stk_pop_q;
  assign stk.stk_top     = stk_top_q;
  assign stk.stk_data_in = stk_data_in_q;

endmodule
`default_nettype wire

// File: doc/stack_cmd_sequencer.md
# stack_cmd_sequencer

Front-end controller placed directly upstream of the N-bit M-deep stack. It accepts stack commands over a valid/ready stream and converts each accepted command into the stack's single-cycle push/pop/top strobes, with enable. It checks full and empty before issuing, so the stack is never commanded illegally. It returns one registered response per command, with data and status, over a second valid/ready stream.

## Interface
Parameters:
- BITWIDTH, 8, data word width; must match the stack.
- STACKSIZE, 32, stack depth; informational only, used by the bench.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  opcode: 01 PUSH, 10 POP, 11 TOP, 00 illegal
- cmd_data  in  BITWIDTH  push operand
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  BITWIDTH  TOP result, or popped value when configured; otherwise 0
- rsp_status  out  2  00 OK, 01 FULL, 10 EMPTY, 11 ILLEGAL
- stk_enable, stk_push, stk_pop, stk_top  out  1 each  stack strobes, one-hot, high for exactly one cycle
- stk_data_in  out  BITWIDTH  push data to stack
- stk_data_out  in  BITWIDTH  stack output register
- stk_overflow  in  1  stack full flag
- stk_is_empty  in  1  stack empty flag

## Operation
- States: IDLE, ISSUE, CAPTURE, ISSUE_POP, RESP.
- cmd_ready = (state == IDLE). All other outputs are registered.
- Transitions out of IDLE (on handshake), with flags sampled in the accept cycle:
  - PUSH while stk_overflow: go to RESP, status FULL, no strobe.
  - POP or TOP while stk_is_empty: go to RESP, status EMPTY, no strobe.
  - op 00: go to RESP, status ILLEGAL, no strobe.
  - Any other command: latch op and data, then go to ISSUE.
- ISSUE drives stk_enable plus one strobe:
  - PUSH and POP go next to RESP.
  - TOP goes next to CAPTURE.
- CAPTURE latches stk_data_out into rsp_data.
  - It goes to RESP, or to ISSUE_POP in a POP sequence when configured.
- ISSUE_POP drives stk_enable and stk_pop, then goes to RESP.
- RESP holds rsp_valid with stable rsp_data and rsp_status until rsp_ready. It returns to IDLE on the handshake edge.
- rsp_data = 0 for PUSH responses, error responses, and unconfigured POP.
- The strobe one-hot invariant holds: at most one of push/pop/top is high, and none is high without stk_enable.
- Reset mid-operation drops any in-flight command and response. A strobe already issued still completes in the stack.

## Timing
- Reset values: state IDLE, cmd_ready 1 after rst_n deasserts (0 while asserted), rsp_valid 0, rsp_data 0, rsp_status 00, all stk_* outputs 0.
- Latency from the accept edge to rsp_valid high:
  - Error responses: 1 cycle.
  - PUSH and POP: 2 cycles.
  - TOP: 3 cycles.
  - POP with data: 4 cycles.
- The strobe is high in the cycle after the accept edge. The stack updates on the edge that ends that cycle.
- Throughput: one command in flight. No new accept until the cycle after the response handshake. If rsp_ready is held high, this gives a peak of one command per 3 cycles for PUSH.
- Backpressure: rsp_ready low holds RESP indefinitely and issues no strobes.

## Configuration
- STACK_SEQ_POP_DATA_EN
  - Defined: POP executes as ISSUE(TOP), then CAPTURE, then ISSUE_POP. rsp_data carries the popped word.
  - Undefined: POP issues a single pop strobe, ISSUE_POP is unreachable, and rsp_data = 0.

## Structure
- stack_seq_pkg contains:
  - op_e (NOP_ILLEGAL, PUSH, POP, TOP)
  - status_e (OK, FULL, EMPTY, ILLEGAL)
  - state_e
  - localparam OP_W = 2
- Single module with no sub-module. The FSM, operand latch and response register are small enough to keep inline.

## Test plan
- Reset then PUSH 0xA5 with rsp_ready=1:
  - stk_push and stk_enable high in exactly one cycle, with stk_data_in=0xA5.
  - Response OK, rsp_data 0x00, 2 cycles after accept.
- PUSH 0x11, PUSH 0x22, then TOP:
  - Response OK with rsp_data 0x22, 3 cycles after accept.
  - Stack contents unchanged.
- POP on an empty stack:
  - Response EMPTY 1 cycle after accept, with no strobe.
  - TOP behaves the same.
  - op 00 returns ILLEGAL.
- PUSH 32 words, then a 33rd PUSH: response FULL, with no stk_push in that command.
- With STACK_SEQ_POP_DATA_EN defined, PUSH 0x3C then POP:
  - stk_top then stk_pop strobes are issued.
  - Response OK with rsp_data 0x3C.
  - stk_is_empty high afterward.
- Hold rsp_ready low for 5 cycles after a TOP:
  - rsp_valid and rsp_data stay stable, cmd_ready stays 0, and no strobes are issued.
  - Then assert rsp_ready and pulse rst_n low mid-response: all outputs return to their reset values immediately.
